popc_accum_thresh: RTL and testbench
====================================

# popc_accum_thresh

Downstream consumer of the popcount stage. It takes pairs of popcount results (positive-product count, negative-product count) one beat per cycle and accumulates their signed difference over a runtime-configurable number of beats, for example the kernel positions of one output pixel. It then compares the sum against two thresholds and emits one ternary activation with a valid/ready handshake. One instance sits behind each output channel's popcount pair, in front of the activation write-back.

## Interface
Parameters:
- `N`, 512: popcount input vector width; each popcount input is `$clog2(N)+1` bits (POPW).
- `MAX_BEATS`, 16: maximum beats per accumulation; power of two.
- Derived `ACCW` = `$clog2(N)+$clog2(MAX_BEATS)+2`, which is 15 at the defaults.

Ports:
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset, synchronous and active-high.
- `clear_i`  in  1: synchronous flush of the partial sum and of the held output.
- `num_beats_i`  in  `$clog2(MAX_BEATS)+1`: beats per accumulation; sampled on the first beat of each accumulation.
- `thresh_lo_i`  in  ACCW signed: lower threshold; sampled on the last beat.
- `thresh_hi_i`  in  ACCW signed: upper threshold; sampled on the last beat.
- `in_valid_i`  in  1: beat valid.
- `in_ready_o`  out  1: beat accepted when high together with `in_valid_i`.
- `popc_pos_i`  in  POPW: unsigned positive popcount.
- `popc_neg_i`  in  POPW: unsigned negative popcount.
- `out_valid_o`  out  1: result valid.
- `out_ready_i`  in  1: consumer ready.
- `out_ternary_o`  out  2: encoded result; 2'b01 = +1, 2'b00 = 0, 2'b11 = -1.
- `out_acc_o`  out  ACCW signed: raw accumulated sum, for debug and bypass.

## Operation
- Per accepted beat, `diff = popc_pos_i - popc_neg_i`, sign-extended to ACCW. The range is ±N, so no overflow is possible at `MAX_BEATS`.
- On the first beat (beat counter = 0), latch the effective beat count:
  - `num_beats_i` = 0 is treated as 1.
  - Values above `MAX_BEATS` clamp to `MAX_BEATS`.
- The accumulator loads `diff` on the first beat and adds `diff` on each later beat. The beat counter increments on each accepted beat.
- On the last beat (counter = latched count - 1), the final sum `acc + diff` is compared against the thresholds, and the result is registered into the output register.
  - Comparison priority: `sum > thresh_hi` gives +1; else `sum < thresh_lo` gives -1; else 0.
  - Equality with either threshold gives 0. Inverted thresholds (lo > hi) follow the same priority.
  - On the same cycle the counter returns to 0.
- FSM has two states:
  - ACC: collecting beats; the output register may be empty or held.
  - `out_valid_o` acts as the second state bit (result held).
- Backpressure rule: `in_ready_o = !rst_i && !clear_i && (!out_valid_o || out_ready_i)`. Intermediate beats are therefore also stalled while a result is stuck; this is intentional to keep the logic simple.
- `clear_i` behaviour:
  - Zeroes the counter, accumulator and `out_valid_o`.
  - Takes priority over any handshake in the same cycle; no beat is accepted and no output is consumed.

## Timing
- Reset values: `in_ready_o` = 0 while `rst_i` is high and 1 after it drops; `out_valid_o` = 0; `out_ternary_o` = 2'b00; `out_acc_o` = 0; internal counter and accumulator = 0.
- Latency: `out_valid_o` rises 1 cycle after the last-beat handshake.
- Throughput: one beat per cycle. Back-to-back accumulations run with no bubble when `out_ready_i` stays high.
- Simultaneous events:
  - Output consumed and new last beat in the same cycle: the new result overwrites the old one, and `out_valid_o` stays high.
  - Output consumed with no new last beat: `out_valid_o` drops the next cycle.
- Output hold: `out_valid_o`, `out_ternary_o` and `out_acc_o` hold stable while valid and not ready. Valid is never withdrawn except by `clear_i` or `rst_i`.
- Reset or clear mid-accumulation discards the partial sum. The next accepted beat is treated as a first beat.

## Structure
- Package `popc_accum_pkg`:
  - Ternary encoding enum (`TERN_POS`, `TERN_ZERO`, `TERN_NEG`).
  - Width helper functions for POPW and ACCW.
- Sub-module `ternary_threshold`: combinational compare of sum against lo/hi, producing the encoding. It is reused by the activation write-back.
- The counter, accumulator and output register live in the top module.

## Test plan
- Three-beat sum: `num_beats`=3; beats (300,100), (50,200), (256,0); lo=-10, hi=100 -> `out_acc_o`=306, `out_ternary_o`=2'b01, one cycle after the third beat.
- Single-beat extremes: `num_beats`=0 (treated as 1) with (0,512), lo=-511 -> acc=-512, -1. Then `num_beats`=16 with (512,0) on every beat -> acc=8192, no overflow.
- Threshold equality: sum = hi = 40 -> 0; sum = lo = -40 -> 0; lo=50, hi=10, sum=30 -> +1.
- Backpressure: hold `out_ready_i`=0 for 5 cycles with a result pending -> `in_ready_o`=0 and outputs stable. Release with a new last beat presented -> consumed and reloaded in the same cycle, and `out_valid_o` stays high.
- Clear: assert `clear_i` after 2 of 4 beats while `in_valid_i` is high -> beat not accepted and the partial sum is dropped. The next 4 beats of (10,0) -> acc=40.
- Reset: `rst_i` while a result is held -> `out_valid_o`=0, acc=0, `in_ready_o`=0 during reset and 1 after.

Source files
------------

// File: rtl/popc_accum_pkg.sv
// Shared types and width helpers for the popcount accumulate/threshold path.
package popc_accum_pkg;

   // Ternary activation encoding; NEG is the two's-complement -1 in two bits.
   typedef enum logic [1:0] {
      TERN_ZERO = 2'b00,
      TERN_POS  = 2'b01,
      TERN_NEG  = 2'b11
   } tern_t;

   // Width of one popcount result for an n-bit input vector (0..n inclusive).
   function automatic int popc_width(input int n);
      return $clog2(n) + 1;
   endfunction

   // Accumulator width: holds +/- n per beat over max_beats beats plus sign.
   function automatic int accum_width(input int n, input int max_beats);
      return $clog2(n) + $clog2(max_beats) + 2;
   endfunction

   // Width of the beat-count port; wide enough to express max_beats itself.
   function automatic int beats_width(input int max_beats);
      return $clog2(max_beats) + 1;
   endfunction

endpackage

// File: rtl/ternary_threshold.sv
// Combinational ternary quantiser: compares a signed sum against lo/hi bounds.
// Upper bound wins when the bounds are inverted; equality maps to zero.
module ternary_threshold
   import popc_accum_pkg::*;
#(
   parameter int W = 15
) (
   input  logic signed [W-1:0] sum,
   input  logic signed [W-1:0] thresh_lo,
   input  logic signed [W-1:0] thresh_hi,
   output tern_t               tern
);

   // Priority compare: above hi first, then below lo, otherwise zero.
   always_comb begin
      tern = TERN_ZERO;
      if (sum > thresh_hi) begin
         tern = TERN_POS;
      end else if (sum < thresh_lo) begin
         tern = TERN_NEG;
      end
   end

endmodule

// File: rtl/popc_accum_thresh.sv
// Accumulates signed popcount differences over a configurable number of beats
// and emits one ternary activation per accumulation over a valid/ready pair.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ACC      | collecting beats; beat_cnt_q counts accepted beats of this group
// OUT_HELD | a finished result sits in the output register (out_valid_o = 1)
//
// Collection never pauses for its own sake: OUT_HELD only gates new beats when
// the consumer is not ready, so the held flag acts as a second state bit.
module popc_accum_thresh
   import popc_accum_pkg::*;
#(
   parameter  int N         = 512,
   parameter  int MAX_BEATS = 16,
   localparam int POPW      = popc_width(N),
   localparam int ACCW      = accum_width(N, MAX_BEATS),
   localparam int BW        = beats_width(MAX_BEATS)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic [BW-1:0]          num_beats_i,
   input  logic signed [ACCW-1:0] thresh_lo_i,
   input  logic signed [ACCW-1:0] thresh_hi_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [POPW-1:0]        popc_pos_i,
   input  logic [POPW-1:0]        popc_neg_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [1:0]             out_ternary_o,
   output logic signed [ACCW-1:0] out_acc_o
);

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_HELD  = 1'b1
   } out_state_t;

   localparam logic [BW-1:0] MAX_BEATS_V = BW'(MAX_BEATS);
   localparam logic [BW-1:0] ONE_BEAT    = BW'(1);

   out_state_t             out_state_q;
   logic [BW-1:0]          beat_cnt_q;
   logic [BW-1:0]          beats_q;
   logic signed [ACCW-1:0] acc_q;
   logic signed [ACCW-1:0] out_acc_q;
   tern_t                  out_tern_q;

   logic                   in_fire;
   logic                   out_fire;
   logic                   first_beat;
   logic                   last_beat;
   logic [BW-1:0]          beats_in;
   logic [BW-1:0]          beats_cur;
   logic signed [ACCW-1:0] diff;
   logic signed [ACCW-1:0] sum_next;
   tern_t                  tern_next;

   assign out_valid_o   = (out_state_q == OUT_HELD);
   assign out_ternary_o = out_tern_q;
   assign out_acc_o     = out_acc_q;

   // A stuck result stalls every beat, not only the last one of a group.
   assign in_ready_o = !rst_i && !clear_i && (!out_valid_o || out_ready_i);
   assign in_fire    = in_valid_i && in_ready_o;
   assign out_fire   = out_valid_o && out_ready_i;

   // Zero-extend both counts before subtracting so the difference is exact.
   assign diff = $signed(ACCW'(popc_pos_i)) - $signed(ACCW'(popc_neg_i));

   // Effective beat count for a new group: 0 means 1, oversize clamps.
   always_comb begin
      if (num_beats_i == '0) begin
         beats_in = ONE_BEAT;
      end else if (num_beats_i > MAX_BEATS_V) begin
         beats_in = MAX_BEATS_V;
      end else begin
         beats_in = num_beats_i;
      end
   end

   // First beat uses the live (clamped) count since beats_q is not yet loaded.
   assign first_beat = (beat_cnt_q == '0);
   assign beats_cur  = first_beat ? beats_in : beats_q;
   assign last_beat  = (beat_cnt_q == (beats_cur - ONE_BEAT));
   assign sum_next   = first_beat ? diff : (acc_q + diff);

   ternary_threshold #(
      .W (ACCW)
   ) u_thresh (
      .sum       (sum_next),
      .thresh_lo (thresh_lo_i),
      .thresh_hi (thresh_hi_i),
      .tern      (tern_next)
   );

   // Beat counter, accumulator, output register and held flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_state_q <= OUT_EMPTY;
         beat_cnt_q  <= '0;
         beats_q     <= '0;
         acc_q       <= '0;
         out_acc_q   <= '0;
         out_tern_q  <= TERN_ZERO;
      end else if (clear_i) begin
         out_state_q <= OUT_EMPTY;
         beat_cnt_q  <= '0;
         acc_q       <= '0;
         out_acc_q   <= '0;
         out_tern_q  <= TERN_ZERO;
      end else begin
         if (out_fire) begin
            out_state_q <= OUT_EMPTY;
         end
         if (in_fire) begin
            if (first_beat) begin
               beats_q <= beats_in;
            end
            if (last_beat) begin
               // New result overrides the consume above in the same cycle.
               beat_cnt_q  <= '0;
               acc_q       <= '0;
               out_acc_q   <= sum_next;
               out_tern_q  <= tern_next;
               out_state_q <= OUT_HELD;
            end else begin
               beat_cnt_q <= beat_cnt_q + ONE_BEAT;
               acc_q      <= sum_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_popc_accum_thresh.sv
// Directed and randomized bench for popc_accum_thresh with a plain-arithmetic
// reference for beat counting, summation and ternary thresholding.
module tb_popc_accum_thresh;

   localparam int N         = 512;
   localparam int MAX_BEATS = 16;
   localparam int POPW      = 10;
   localparam int ACCW      = 15;
   localparam int BW        = 5;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   clear_i;
   logic [BW-1:0]          num_beats_i;
   logic signed [ACCW-1:0] thresh_lo_i;
   logic signed [ACCW-1:0] thresh_hi_i;
   logic                   in_valid_i;
   logic                   in_ready_o;
   logic [POPW-1:0]        popc_pos_i;
   logic [POPW-1:0]        popc_neg_i;
   logic                   out_valid_o;
   logic                   out_ready_i;
   logic [1:0]             out_ternary_o;
   logic signed [ACCW-1:0] out_acc_o;

   int checks   = 0;
   int failures = 0;

   popc_accum_thresh #(
      .N         (N),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .num_beats_i   (num_beats_i),
      .thresh_lo_i   (thresh_lo_i),
      .thresh_hi_i   (thresh_hi_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .popc_pos_i    (popc_pos_i),
      .popc_neg_i    (popc_neg_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_ternary_o (out_ternary_o),
      .out_acc_o     (out_acc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: ternary code as an integer (1 = +1, 3 = -1, 0 = zero).
   function automatic int ref_tern(input int sum, input int lo, input int hi);
      if (sum > hi) return 1;
      if (sum < lo) return 3;
      return 0;
   endfunction

   function automatic int ref_beats(input int nb);
      if (nb == 0) return 1;
      if (nb > MAX_BEATS) return MAX_BEATS;
      return nb;
   endfunction

   task automatic set_cfg(input int nb, input int lo, input int hi);
      num_beats_i = BW'(nb);
      thresh_lo_i = ACCW'(lo);
      thresh_hi_i = ACCW'(hi);
   endtask

   // Presents one beat and returns 1 time unit after the accepting edge.
   task automatic do_beat(input int p, input int n);
      int budget;
      budget      = 50;
      in_valid_i  = 1'b1;
      popc_pos_i  = POPW'(p);
      popc_neg_i  = POPW'(n);
      @(negedge clk_i);
      while (!in_ready_o && budget > 0) begin
         @(negedge clk_i);
         budget--;
      end
      check("beat_ready", int'(in_ready_o), 1);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic check_result(input string tag, input int acc, input int tern);
      check({tag, "_valid"}, int'(out_valid_o), 1);
      check({tag, "_acc"}, int'(out_acc_o), acc);
      check({tag, "_tern"}, int'(out_ternary_o), tern);
   endtask

   initial begin
      int nb, eff, lo, hi, sum, p, n, gap;

      rst_i       = 1'b1;
      clear_i     = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      popc_pos_i  = '0;
      popc_neg_i  = '0;
      set_cfg(1, 0, 0);

      // Reset state
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_in_ready", int'(in_ready_o), 0);
      check("rst_out_valid", int'(out_valid_o), 0);
      check("rst_acc", int'(out_acc_o), 0);
      check("rst_tern", int'(out_ternary_o), 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      check("post_rst_ready", int'(in_ready_o), 1);

      // Three-beat sum
      set_cfg(3, -10, 100);
      do_beat(300, 100);
      check("three_mid1_valid", int'(out_valid_o), 0);
      do_beat(50, 200);
      check("three_mid2_valid", int'(out_valid_o), 0);
      do_beat(256, 0);
      check_result("three", 306, 1);
      @(posedge clk_i);
      #1;
      check("three_consumed", int'(out_valid_o), 0);

      // Single-beat extreme with num_beats = 0
      set_cfg(0, -511, 0);
      do_beat(0, 512);
      check_result("single_neg", -512, 3);

      // Full-length accumulation at maximum magnitude
      set_cfg(16, -10, 100);
      for (int i = 0; i < 16; i++) begin
         do_beat(512, 0);
         if (i < 15) check("max_mid_valid", int'(out_valid_o), 0);
      end
      check_result("max16", 8192, 1);

      // Oversize count clamps to MAX_BEATS
      set_cfg(25, -10, 100);
      for (int i = 0; i < 16; i++) begin
         do_beat(1, 3);
         if (i < 15) check("clamp_mid_valid", int'(out_valid_o), 0);
      end
      check_result("clamp", -32, 3);

      // Threshold equality and inverted thresholds
      set_cfg(1, -40, 40);
      do_beat(40, 0);
      check_result("eq_hi", 40, 0);
      do_beat(0, 40);
      check_result("eq_lo", -40, 0);
      set_cfg(1, 50, 10);
      do_beat(30, 0);
      check_result("inverted", 30, 1);

      // Backpressure: result held, new last beat waiting
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b0;
      set_cfg(1, -10, 100);
      do_beat(5, 0);
      check_result("bp_first", 5, 0);
      in_valid_i = 1'b1;
      popc_pos_i = POPW'(200);
      popc_neg_i = POPW'(0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("bp_in_ready", int'(in_ready_o), 0);
         check_result("bp_hold", 5, 0);
      end
      out_ready_i = 1'b1;
      #1;
      check("bp_release_ready", int'(in_ready_o), 1);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      check_result("bp_reload", 200, 1);
      @(posedge clk_i);
      #1;
      check("bp_drained", int'(out_valid_o), 0);

      // Clear mid-accumulation with a beat presented
      set_cfg(4, -10, 100);
      do_beat(100, 0);
      do_beat(100, 0);
      in_valid_i = 1'b1;
      popc_pos_i = POPW'(100);
      popc_neg_i = POPW'(0);
      clear_i    = 1'b1;
      @(negedge clk_i);
      check("clr_in_ready", int'(in_ready_o), 0);
      @(posedge clk_i);
      #1;
      clear_i    = 1'b0;
      in_valid_i = 1'b0;
      check("clr_out_valid", int'(out_valid_o), 0);
      for (int i = 0; i < 4; i++) begin
         do_beat(10, 0);
         if (i < 3) check("clr_mid_valid", int'(out_valid_o), 0);
      end
      check_result("clr_after", 40, 0);

      // Reset while a result is held
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b0;
      set_cfg(1, -10, 100);
      do_beat(9, 0);
      check_result("rst_held", 9, 0);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("rst2_in_ready", int'(in_ready_o), 0);
      @(posedge clk_i);
      #1;
      check("rst2_out_valid", int'(out_valid_o), 0);
      check("rst2_acc", int'(out_acc_o), 0);
      rst_i = 1'b0;
      #1;
      check("rst2_ready_after", int'(in_ready_o), 1);
      out_ready_i = 1'b1;

      // Reset mid-accumulation discards the partial sum
      set_cfg(3, -10, 100);
      do_beat(50, 0);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      set_cfg(2, -10, 100);
      do_beat(1, 0);
      check("rst_mid_valid", int'(out_valid_o), 0);
      do_beat(2, 0);
      check_result("rst_mid", 3, 0);

      // Randomized groups; config scrambled outside its sampling beat
      for (int g = 0; g < 30; g++) begin
         nb  = int'($urandom_range(0, 31));
         eff = ref_beats(nb);
         lo  = int'($urandom_range(0, 4000)) - 2000;
         hi  = int'($urandom_range(0, 4000)) - 2000;
         sum = 0;
         for (int b = 0; b < eff; b++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
               @(posedge clk_i);
               #1;
            end
            num_beats_i = (b == 0) ? BW'(nb) : BW'($urandom_range(0, 31));
            if (b == eff - 1) begin
               thresh_lo_i = ACCW'(lo);
               thresh_hi_i = ACCW'(hi);
            end else begin
               thresh_lo_i = ACCW'(int'($urandom_range(0, 4000)) - 2000);
               thresh_hi_i = ACCW'(int'($urandom_range(0, 4000)) - 2000);
            end
            p = int'($urandom_range(0, N));
            n = int'($urandom_range(0, N));
            sum += p - n;
            do_beat(p, n);
            if (b < eff - 1) check("rand_mid_valid", int'(out_valid_o), 0);
         end
         check_result("rand", sum, ref_tern(sum, lo, hi));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
